fc_dense_layer: RTL
===================

// Module: fc_dense_layer
// PURPOSE
//  Fully connected layer downstream of the flatten stage. Consumes the serial element stream
//  (one BITWIDTH word per valid cycle), multiplies each element by a row of weights and accumulates
//  into OUT_LEN parallel signed accumulators. After IN_LEN elements it adds bias, rescales,
//  saturates and optionally applies ReLU. It then streams OUT_LEN results serially to the next stage.
// PARAMETERS
//  BITWIDTH  16   word width; signed fixed point, FRAC fractional bits
//  FRAC      8    fractional bits of inputs, weights, bias and outputs
//  IN_LEN    588  elements per frame (14*14*3); max 1024
//  OUT_LEN   10   neurons; max 64
//  RELU      0    1: clamp negative results to 0 after saturation
// PORTS
//  clk            in   1                  clock, all logic on rising edge
//  rst            in   1                  asynchronous, active-high reset
//  clken          in   1                  clock enable; low = all state frozen, inputs ignored
//  data_in        in   BITWIDTH           element from flatten stage (signed)
//  data_in_valid  in   1                  data_in valid this cycle
//  weight_addr    out  10                 index of next expected element (row select)
//  weight_row     in   OUT_LEN*BITWIDTH   row weight_addr from async-read ROM; neuron j at [j*BW +: BW]
//  bias           in   OUT_LEN*BITWIDTH   per-neuron bias, same packing; sampled in ST_FINAL
//  data_out       out  BITWIDTH           result word (signed, saturated)
//  data_out_valid out  1                  data_out valid
//  done           out  1                  1-cycle pulse with the last result of a frame
//  overrun        out  1                  sticky: input arrived while not in ST_ACC
// BEHAVIOUR
//  Reset: state=ST_ACC, in_cnt=0, accumulators=0, out_idx=0, all outputs 0.
//  weight_addr = in_cnt, registered. The ROM is combinational; weight_row is used in the same cycle.
//  States, evaluated only when clken=1:
//   ST_ACC: on data_in_valid, acc[j] += data_in*weight_row[j] for all j, and in_cnt++.
//     On the IN_LEN-th element, in_cnt<=0 and the state goes to ST_FINAL.
//     The first element of a frame (in_cnt==0) loads acc[j] = product, so no clear cycle is needed.
//   ST_FINAL (1 cycle): res[j] = sat(((acc[j] + (bias[j] <<< FRAC)) >>> FRAC)); apply ReLU if
//     RELU=1; go to ST_OUT with out_idx=0.
//   ST_OUT: data_out<=res[out_idx], data_out_valid<=1, out_idx++. When out_idx==OUT_LEN-1,
//     done<=1 for that cycle, then go to ST_ACC. data_out_valid and done are 0 in all other cycles.
//  Latency: last input accepted at edge T -> ST_FINAL at T+1 -> first output at edge T+2;
//    last output and done at edge T+1+OUT_LEN.
//  Arithmetic:
//   - product is 2*BITWIDTH signed; accumulator width is 2*BITWIDTH+10 signed, so it never wraps.
//   - >>> is an arithmetic shift (truncation toward -inf).
//   - sat clamps to [-2^(BW-1), 2^(BW-1)-1].
//  Boundaries:
//   - data_in_valid in ST_FINAL/ST_OUT: the element is dropped, overrun<=1 (sticky until rst),
//     and the accumulators are untouched.
//   - clken=0 mid-frame: the count, accumulators and outputs hold. data_out_valid/done hold their
//     registered values but carry no new data; the consumer qualifies them with clken.
//   - rst asserted mid-frame or mid-output: immediate return to reset values; the partial frame
//     is discarded.
//   - data_in_valid held continuously across frames: element IN_LEN+1 arrives in ST_FINAL and
//     sets overrun. The upstream flatten stage must gap frames by >= OUT_LEN+1 cycles.
// TESTING (IN_LEN=4, OUT_LEN=2, FRAC=8 unless noted)
//  1 all weights 0x0100, bias 0, inputs 0x0100,0x0200,0x0300,0x0400 back-to-back
//    -> outputs 0x0A00,0x0A00 at T+2,T+3; done with the 2nd output; weight_addr 0,1,2,3.
//  2 weights 0x7FFF, inputs 0x7FFF x4 -> both outputs 0x7FFF; neuron1 weights 0x8000 -> 0x8000.
//  3 neuron0 weight 0xFF00 (-1.0), inputs 0x0100 x4, bias0=0x0100 -> 0xFD00 (RELU=0), 0x0000 (RELU=1).
//  4 clken toggled 1,0,1,0 during input and output -> same results as test 1, each output held
//    across the gap cycles.
//  5 rst pulse after 2 inputs, then a full new frame -> results reflect only the new frame;
//    overrun=0.
//  6 a 5th data_in_valid right after the 4th -> overrun=1 stays set; results equal test 1.

Source files
------------

// File: rtl/fc_dense_layer.sv
// fc_dense_layer
//   Fully connected layer fed by a serial element stream. Each accepted element is
//   multiplied by one ROM row of weights and accumulated into OUT_LEN signed
//   accumulators. After IN_LEN elements, bias is added, the sum is rescaled by FRAC,
//   saturated, optionally ReLU-clamped, and the OUT_LEN results are streamed out serially.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clken           clock enable; low freezes all state and ignores inputs
//   data_in/_valid  signed input element stream
//   weight_addr     registered index of the next expected element (ROM row select)
//   weight_row      combinational ROM row, neuron j at [j*BITWIDTH +: BITWIDTH]
//   bias            per-neuron bias, same packing, sampled in ST_FINAL
//   data_out/_valid serial signed results
//   done            pulses with the last result of a frame
//   overrun         sticky: an element arrived while not accumulating
module fc_dense_layer #(
    parameter int BITWIDTH = 16,
    parameter int FRAC     = 8,
    parameter int IN_LEN   = 588,
    parameter int OUT_LEN  = 10,
    parameter int RELU     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken,
    input  logic [BITWIDTH-1:0]           data_in,
    input  logic                          data_in_valid,
    output logic [9:0]                    weight_addr,
    input  logic [OUT_LEN*BITWIDTH-1:0]   weight_row,
    input  logic [OUT_LEN*BITWIDTH-1:0]   bias,
    output logic [BITWIDTH-1:0]           data_out,
    output logic                          data_out_valid,
    output logic                          done,
    output logic                          overrun
);

    // 10 guard bits cover up to 1024 full-scale products without wrapping
    localparam int AW = 2*BITWIDTH + 10;
    localparam int OW = 6;
    localparam logic [9:0]    LAST_IN  = 10'(IN_LEN - 1);
    localparam logic [OW-1:0] LAST_OUT = OW'(OUT_LEN - 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (BITWIDTH-1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {ST_ACC, ST_FINAL, ST_OUT} state_t;

    state_t                     state_q, state_d;
    logic [9:0]                 in_cnt_q, in_cnt_d;
    logic [OW-1:0]              out_idx_q, out_idx_d;
    logic signed [AW-1:0]       acc_q [OUT_LEN];
    logic signed [AW-1:0]       acc_d [OUT_LEN];
    logic signed [BITWIDTH-1:0] res_q [OUT_LEN];
    logic signed [BITWIDTH-1:0] res_d [OUT_LEN];
    logic [BITWIDTH-1:0]        data_out_q, data_out_d;
    logic                       data_out_valid_q, data_out_valid_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;

    function automatic logic signed [AW-1:0] mac_term(input logic [BITWIDTH-1:0] a,
                                                      input logic [BITWIDTH-1:0] b);
        logic signed [2*BITWIDTH-1:0] p;
        p = $signed(a) * $signed(b);
        return {{(AW-2*BITWIDTH){p[2*BITWIDTH-1]}}, p};
    endfunction

    // bias is aligned to the product scale (2*FRAC fraction bits) before rescaling
    function automatic logic signed [BITWIDTH-1:0] finalize(input logic signed [AW-1:0] acc,
                                                            input logic [BITWIDTH-1:0] b);
        logic signed [AW-1:0] sum;
        sum = acc + ({{(AW-BITWIDTH){b[BITWIDTH-1]}}, b} <<< FRAC);
        sum = sum >>> FRAC;
        if (sum > SAT_MAX)      sum = SAT_MAX;
        else if (sum < SAT_MIN) sum = SAT_MIN;
        if (RELU != 0 && sum < 0) sum = '0;
        return sum[BITWIDTH-1:0];
    endfunction

    always_comb begin
        state_d          = state_q;
        in_cnt_d         = in_cnt_q;
        out_idx_d        = out_idx_q;
        acc_d            = acc_q;
        res_d            = res_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        done_d           = done_q;
        overrun_d        = overrun_q;
        if (clken) begin
            data_out_valid_d = 1'b0;
            done_d           = 1'b0;
            if (data_in_valid && state_q != ST_ACC) overrun_d = 1'b1;
            case (state_q)
                ST_ACC: begin
                    if (data_in_valid) begin
                        // first element loads instead of adding: no clear cycle between frames
                        for (int j = 0; j < OUT_LEN; j++) begin
                            acc_d[j] = mac_term(data_in, weight_row[j*BITWIDTH +: BITWIDTH]);
                            if (in_cnt_q != '0) acc_d[j] = acc_q[j] + acc_d[j];
                        end
                        if (in_cnt_q == LAST_IN) begin
                            in_cnt_d = '0;
                            state_d  = ST_FINAL;
                        end else begin
                            in_cnt_d = in_cnt_q + 10'd1;
                        end
                    end
                end
                ST_FINAL: begin
                    for (int j = 0; j < OUT_LEN; j++)
                        res_d[j] = finalize(acc_q[j], bias[j*BITWIDTH +: BITWIDTH]);
                    out_idx_d = '0;
                    state_d   = ST_OUT;
                end
                ST_OUT: begin
                    data_out_d       = res_q[out_idx_q];
                    data_out_valid_d = 1'b1;
                    if (out_idx_q == LAST_OUT) begin
                        done_d    = 1'b1;
                        out_idx_d = '0;
                        state_d   = ST_ACC;
                    end else begin
                        out_idx_d = out_idx_q + OW'(1);
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_ACC;
            in_cnt_q         <= '0;
            out_idx_q        <= '0;
            for (int j = 0; j < OUT_LEN; j++) begin
                acc_q[j] <= '0;
                res_q[j] <= '0;
            end
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            done_q           <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            in_cnt_q         <= in_cnt_d;
            out_idx_q        <= out_idx_d;
            acc_q            <= acc_d;
            res_q            <= res_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            done_q           <= done_d;
            overrun_q        <= overrun_d;
        end
    end

    assign weight_addr    = in_cnt_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign done           = done_q;
    assign overrun        = overrun_q;

endmodule
